// File: rtl/spi_master_gen2.sv
// SPI master core: 4 CPOL/CPHA modes, MSB/LSB-first, valid/ready frame interface.
// Optional mode-fault detection (ss_in, modf_out, modf_clr_in) under `SPI_MASTER_GEN2_MODF_EN.
module spi_master_gen2 #(
  parameter int DATA_W = 8,
  parameter int SS_NUM = 1,
  parameter int DIV_W  = 8
) (
  input  logic                    clk_in,
  input  logic                    rstn_in,
  input  logic                    enable_in,
  input  logic                    cpol_in,
  input  logic                    cpha_in,
  input  logic                    lsbfe_in,
  input  logic [DIV_W-1:0]        clk_div_in,
  input  logic [$clog2(SS_NUM):0] ss_sel_in,
  input  logic                    tx_valid_in,
  input  logic [DATA_W-1:0]       tx_data_in,
  output logic                    tx_ready_out,
  output logic                    rx_valid_out,
  output logic [DATA_W-1:0]       rx_data_out,
  output logic                    busy_out,
  output logic                    sck_out,
  output logic                    mosi_out,
`ifdef SPI_MASTER_GEN2_MODF_EN
  input  logic                    ss_in,
  input  logic                    modf_clr_in,
  output logic                    modf_out,
`endif
  input  logic                    miso_in,
  output logic [SS_NUM-1:0]       ss_n_out
);

  localparam int SEL_W = $clog2(SS_NUM) + 1;
  localparam int EW    = $clog2(2*DATA_W + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] XFER  = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  logic [1:0]        state;
  logic [DIV_W-1:0]  cnt, div_q;
  logic [EW-1:0]     edge_cnt, edge_nxt;
  logic [DATA_W-1:0] tx_sh, rx_sh;
  logic [SEL_W-1:0]  sel_q;
  logic              cpha_q, lsb_q;
  logic              tick, accept, abort, lead, last_edge;

  function automatic logic first_bit(input logic [DATA_W-1:0] d, input logic lsb);
    return lsb ? d[0] : d[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] d, input logic lsb);
    return lsb ? {1'b0, d[DATA_W-1:1]} : {d[DATA_W-2:0], 1'b0};
  endfunction

`ifdef SPI_MASTER_GEN2_MODF_EN
  logic modf_q, modf_set;
  // another master pulling our SS low while enabled is a mode fault
  assign modf_set     = enable_in & ~ss_in;
  assign abort        = ~enable_in | modf_set;
  assign tx_ready_out = (state == IDLE) & enable_in & ~modf_q;
  assign modf_out     = modf_q;

  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in)         modf_q <= 1'b0;
    else if (modf_set)    modf_q <= 1'b1;
    else if (modf_clr_in) modf_q <= 1'b0;
  end
`else
  assign abort        = ~enable_in;
  assign tx_ready_out = (state == IDLE) & enable_in;
`endif

  assign accept    = tx_valid_in & tx_ready_out;
  assign tick      = (cnt == '0);
  assign edge_nxt  = edge_cnt + 1'b1;
  assign lead      = edge_nxt[0];
  assign last_edge = (edge_nxt == EW'(2*DATA_W));
  assign busy_out  = (state != IDLE);

  always_comb begin
    ss_n_out = '1;
    for (int i = 0; i < SS_NUM; i++)
      if (state != IDLE && sel_q == SEL_W'(i)) ss_n_out[i] = 1'b0;
  end

  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      state        <= IDLE;
      cnt          <= '0;
      div_q        <= '0;
      edge_cnt     <= '0;
      tx_sh        <= '0;
      rx_sh        <= '0;
      sel_q        <= '0;
      cpha_q       <= 1'b0;
      lsb_q        <= 1'b0;
      sck_out      <= 1'b0;
      mosi_out     <= 1'b0;
      rx_valid_out <= 1'b0;
      rx_data_out  <= '0;
    end else begin
      rx_valid_out <= 1'b0;
      cnt          <= tick ? div_q : cnt - 1'b1;
      case (state)
        IDLE: begin
          sck_out <= cpol_in;
          if (accept) begin
            state    <= SETUP;
            cnt      <= clk_div_in;
            div_q    <= clk_div_in;
            cpha_q   <= cpha_in;
            lsb_q    <= lsbfe_in;
            edge_cnt <= '0;
            sel_q    <= (ss_sel_in < SEL_W'(SS_NUM)) ? ss_sel_in : '0;
            // CPHA=0 must present the first bit before the first sampling edge
            if (cpha_in) tx_sh <= tx_data_in;
            else begin
              mosi_out <= first_bit(tx_data_in, lsbfe_in);
              tx_sh    <= shift_out(tx_data_in, lsbfe_in);
            end
          end
        end
        SETUP: if (tick) begin
          state <= XFER;
          cnt   <= div_q;
        end
        XFER: if (tick) begin
          sck_out  <= ~sck_out;
          edge_cnt <= edge_nxt;
          // sampling edge is the leading one for CPHA=0, the trailing one for CPHA=1
          if (lead ^ cpha_q)
            rx_sh <= lsb_q ? {miso_in, rx_sh[DATA_W-1:1]} : {rx_sh[DATA_W-2:0], miso_in};
          else if (!last_edge) begin
            mosi_out <= first_bit(tx_sh, lsb_q);
            tx_sh    <= shift_out(tx_sh, lsb_q);
          end
          if (last_edge) begin
            state <= HOLD;
            cnt   <= div_q;
          end
        end
        HOLD: if (tick) begin
          state        <= IDLE;
          rx_data_out  <= rx_sh;
          rx_valid_out <= 1'b1;
        end
      endcase
      if (state != IDLE && abort) begin
        state        <= IDLE;
        cnt          <= div_q;
        sck_out      <= cpol_in;
        rx_valid_out <= 1'b0;
        rx_data_out  <= rx_data_out;
      end
    end
  end

endmodule
